spart_bus_ctrl: RTL and testbench
=================================

SPART_BUS_CTRL -- requirements
Module: spart_bus_ctrl

Interface
REQ-001 Parameter DIV_RESET, 16'd162, baud divisor loaded at reset (50 MHz clock, 19200 baud, 16x oversample).
REQ-002 clk  input  1  system clock; all state on posedge clk.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 iocs  input  1  chip select from processor bus.
REQ-005 iorw  input  1  1 = read, 0 = write.
REQ-006 ioaddr  input  2  register select: 00 data, 01 status, 10 divisor low, 11 divisor high.
REQ-007 databus_in  input  8  write data from processor.
REQ-008 databus_out  output  8  registered read data.
REQ-009 rda  input  1  receiver data-available flag.
REQ-010 tbr  input  1  transmitter buffer-ready flag.
REQ-011 rx_data  input  8  received byte from receiver.
REQ-012 rx_read  output  1  one-cycle pulse; receiver consumes byte.
REQ-013 tx_write  output  1  one-cycle pulse; transmitter loads tx_data.
REQ-014 tx_data  output  8  byte to transmit, registered.
REQ-015 baud_en  output  1  one-cycle 16x-oversample tick to receiver/transmitter enable inputs.

Function
REQ-016 Access = iocs high; each access yields exactly one strobe, on the first cycle iocs is high (rising edge of registered iocs); iocs held N cycles still yields one pulse.
REQ-017 Read addr 00: rx_read pulses one cycle after access start; databus_out = rx_data in the same cycle.
REQ-018 Write addr 00: tx_write pulses one cycle after access start; tx_data = databus_in captured at access start; tx_write issued regardless of tbr (no blocking).
REQ-019 Read addr 01: databus_out = {6'b0, tbr, rda}, one cycle after access start; status read has no side effects.
REQ-020 Write addr 10: stage databus_in in div_lo shadow; active divisor unchanged.
REQ-021 Write addr 11: divisor = {databus_in, div_lo} becomes active; counter reloads with it next cycle (atomic 16-bit update).
REQ-022 Writes to addr 01 and reads of unmapped data ignored; databus_out holds last value when no read.
REQ-023 Baud generator FSM: HALT (divisor 0, baud_en low), LOAD (counter <= divisor-1), COUNT (decrement; at 0 pulse baud_en, reload divisor-1).
REQ-024 Tick period = divisor cycles exactly; divisor 1 gives baud_en high every cycle.
REQ-025 Divisor write of 0 -> HALT; nonzero write from HALT -> LOAD next cycle, first tick divisor cycles later.
REQ-026 Tick and divisor-high write same cycle: tick still issued, counter loads new divisor-1.
REQ-027 Counter 16-bit unsigned, no wrap below 0 (reload at 0).

Reset
REQ-028 On rst: databus_out 0, tx_data 0, rx_read 0, tx_write 0, baud_en 0, div_lo DIV_RESET[7:0], divisor DIV_RESET, FSM LOAD.
REQ-029 Reset mid-access: strobes cancelled; access still held after release produces no strobe until iocs drops and rises again.
REQ-030 First baud_en after reset release occurs DIV_RESET+1 cycles later.

Configuration
REQ-031 Macro SPART_DIVREAD_EN defined: reads of addr 10/11 return active divisor low/high byte.
REQ-032 Macro SPART_DIVREAD_EN undefined: reads of addr 10/11 return 8'h00; no readback logic compiled.

Structure
REQ-033 Shared package spart_pkg: address constants (ADDR_DATA, ADDR_STATUS, ADDR_DBLO, ADDR_DBHI), status bit positions, DIV_RESET default, baud FSM state typedef.
REQ-034 Sub-module spart_baud_gen holds divisor counter and FSM; top holds bus decode, strobes, shadow register.

Verification
REQ-035 Reset, no access -> baud_en pulses every 162 cycles, first at cycle 163.
REQ-036 Write 10=8'h05, then 11=8'h00 -> baud_en period 5 cycles from second cycle after high write; write 11=0 with lo 0 -> baud_en stays low.
REQ-037 rda=1, rx_data=8'hA5, read 00 with iocs held 4 cycles -> databus_out 8'hA5, exactly one rx_read pulse.
REQ-038 Write 00 data 8'h3C -> tx_data 8'h3C, one tx_write pulse; read 01 with tbr=1, rda=0 -> 8'h02.
REQ-039 Assert rst during held read -> rx_read 0; no pulse after release until iocs retoggles.
REQ-040 With SPART_DIVREAD_EN, read 11 after reset -> 8'h00, read 10 -> 8'hA2; without macro both -> 8'h00.

Source files
------------

// File: rtl/spart_pkg.sv
// spart_pkg
// Shared definitions for the SPART processor-bus controller:
//   - register map addresses seen on ioaddr
//   - bit positions inside the status byte
//   - default baud divisor (50 MHz clock, 19200 baud, 16x oversample)
//   - baud generator FSM state type
//   - helper that packs the status byte
package spart_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;
    localparam logic [1:0] ADDR_DBLO   = 2'b10;
    localparam logic [1:0] ADDR_DBHI   = 2'b11;

    localparam int STAT_RDA = 0;
    localparam int STAT_TBR = 1;

    localparam logic [15:0] DIV_RESET_DEFAULT = 16'd162;

    typedef enum logic [1:0] {
        BAUD_HALT  = 2'd0,
        BAUD_LOAD  = 2'd1,
        BAUD_COUNT = 2'd2
    } baud_state_t;

    function automatic logic [7:0] status_byte(input logic tbr, input logic rda);
        logic [7:0] s;
        s           = 8'h00;
        s[STAT_TBR] = tbr;
        s[STAT_RDA] = rda;
        return s;
    endfunction

endpackage

// File: rtl/spart_baud_gen.sv
// spart_baud_gen
// Divisor-driven 16x oversample tick generator.
//   clk      in   system clock
//   rst      in   asynchronous active-high reset (FSM restarts in LOAD)
//   divisor  in   active 16-bit divisor (owned by the bus controller)
//   div_wr   in   one-cycle pulse: a new divisor is being made active
//   div_new  in   the divisor value written alongside div_wr
//   baud_en  out  registered one-cycle tick, period = divisor cycles
module spart_baud_gen
    import spart_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] divisor,
    input  logic        div_wr,
    input  logic [15:0] div_new,
    output logic        baud_en
);

    baud_state_t state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic        baud_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= BAUD_LOAD;
            cnt     <= 16'd0;
            baud_en <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            baud_en <= baud_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        baud_nxt  = 1'b0;
        case (state)
            BAUD_HALT: begin
                cnt_nxt = 16'd0;
            end
            BAUD_LOAD: begin
                if (divisor == 16'd0) begin
                    state_nxt = BAUD_HALT;
                end else begin
                    cnt_nxt   = divisor - 16'd1;
                    state_nxt = BAUD_COUNT;
                end
            end
            BAUD_COUNT: begin
                // Reload at zero instead of wrapping; a divisor of 1
                // therefore keeps the counter at 0 and ticks every cycle.
                if (cnt == 16'd0) begin
                    baud_nxt = 1'b1;
                    cnt_nxt  = divisor - 16'd1;
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
            default: begin
                state_nxt = BAUD_LOAD;
            end
        endcase
        // A divisor write overrides the sequencing but not a tick already
        // due this cycle, so no baud_en pulse is ever swallowed.
        if (div_wr) begin
            state_nxt = (div_new == 16'd0) ? BAUD_HALT : BAUD_LOAD;
        end
    end

endmodule

// File: rtl/spart_bus_ctrl.sv
// spart_bus_ctrl
// Processor-bus side of the SPART: register decode, one-shot strobes to the
// receiver/transmitter, divisor shadow/active registers and the baud
// generator instance.
//   clk, rst            clock, asynchronous active-high reset
//   iocs, iorw, ioaddr  bus chip select, 1=read/0=write, register select
//   databus_in          write data from the processor
//   databus_out         registered read data (holds between reads)
//   rda, tbr, rx_data   receiver/transmitter status and received byte
//   rx_read, tx_write   one-cycle strobes to receiver / transmitter
//   tx_data             registered byte to transmit
//   baud_en             16x oversample tick
// Build option: define SPART_DIVREAD_EN to make the divisor bytes readable
// at addresses 10/11; otherwise those reads return 8'h00.
module spart_bus_ctrl
    import spart_pkg::*;
#(
    parameter logic [15:0] DIV_RESET = DIV_RESET_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    input  logic [7:0] databus_in,
    output logic [7:0] databus_out,
    input  logic       rda,
    input  logic       tbr,
    input  logic [7:0] rx_data,
    output logic       rx_read,
    output logic       tx_write,
    output logic [7:0] tx_data,
    output logic       baud_en
);

    logic        iocs_p1;
    logic        acc_start;
    logic        rd_start;
    logic        wr_start;
    logic [7:0]  div_lo;
    logic [15:0] divisor;
    logic        div_wr;
    logic [15:0] div_new;
    logic [7:0]  rd_mux;

    // Access detect: rising edge of iocs against its registered copy.
    assign acc_start = iocs & ~iocs_p1;
    assign rd_start  = acc_start &  iorw;
    assign wr_start  = acc_start & ~iorw;

    assign div_wr  = wr_start && (ioaddr == ADDR_DBHI);
    assign div_new = {databus_in, div_lo};

    always_comb begin
        rd_mux = 8'h00;
        case (ioaddr)
            ADDR_DATA:   rd_mux = rx_data;
            ADDR_STATUS: rd_mux = status_byte(tbr, rda);
`ifdef SPART_DIVREAD_EN
            ADDR_DBLO:   rd_mux = divisor[7:0];
            ADDR_DBHI:   rd_mux = divisor[15:8];
`endif
            default:     rd_mux = 8'h00;
        endcase
    end

    // Stage p1: strobes, read data and register updates launched from the
    // access-start cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // iocs_p1 resets high so an access still held across reset
            // release is not seen as a new rising edge.
            iocs_p1     <= 1'b1;
            rx_read     <= 1'b0;
            tx_write    <= 1'b0;
            databus_out <= 8'h00;
            tx_data     <= 8'h00;
            div_lo      <= DIV_RESET[7:0];
            divisor     <= DIV_RESET;
        end else begin
            iocs_p1  <= iocs;
            rx_read  <= rd_start && (ioaddr == ADDR_DATA);
            tx_write <= wr_start && (ioaddr == ADDR_DATA);
            if (rd_start) begin
                databus_out <= rd_mux;
            end
            if (wr_start && (ioaddr == ADDR_DATA)) begin
                tx_data <= databus_in;
            end
            if (wr_start && (ioaddr == ADDR_DBLO)) begin
                div_lo <= databus_in;
            end
            if (div_wr) begin
                divisor <= div_new;
            end
        end
    end

    spart_baud_gen u_baud_gen (
        .clk     (clk),
        .rst     (rst),
        .divisor (divisor),
        .div_wr  (div_wr),
        .div_new (div_new),
        .baud_en (baud_en)
    );

endmodule

// File: tb/tb_spart_bus_ctrl.sv
// tb_spart_bus_ctrl
// Directed bench for spart_bus_ctrl: reset state, baud timing for several
// divisors, data/status/divisor register accesses and reset during an access.
module tb_spart_bus_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       iocs = 1'b0;
    logic       iorw = 1'b1;
    logic [1:0] ioaddr = 2'b00;
    logic [7:0] databus_in = 8'h00;
    logic [7:0] databus_out;
    logic       rda = 1'b0;
    logic       tbr = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_read;
    logic       tx_write;
    logic [7:0] tx_data;
    logic       baud_en;

    int tests = 0;
    int fails = 0;
    int rx_cnt = 0;
    int tx_cnt = 0;

    logic [7:0] rd_q[$];
    logic [7:0] tx_q[$];

    always #5 clk = ~clk;

    spart_bus_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .iocs        (iocs),
        .iorw        (iorw),
        .ioaddr      (ioaddr),
        .databus_in  (databus_in),
        .databus_out (databus_out),
        .rda         (rda),
        .tbr         (tbr),
        .rx_data     (rx_data),
        .rx_read     (rx_read),
        .tx_write    (tx_write),
        .tx_data     (tx_data),
        .baud_en     (baud_en)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Strobe monitor: counts receiver pulses, pops the transmit scoreboard.
    always @(negedge clk) begin
        if (rx_read === 1'b1) rx_cnt++;
        if (tx_write === 1'b1) begin
            tx_cnt++;
            if (tx_q.size() == 0)
                check("tx_unexpected", 16'(tx_q.size()), 16'd1);
            else
                check("tx_data", 16'(tx_data), 16'(tx_q.pop_front()));
        end
    end

    // All tasks are entered right after a falling edge.
    task automatic bus_read(input logic [1:0] a, input logic [7:0] exp, input int hold,
                            input string tag);
        logic [7:0] e;
        rd_q.push_back(exp);
        iocs = 1'b1; iorw = 1'b1; ioaddr = a;
        @(negedge clk);
        e = rd_q.pop_front();
        check(tag, 16'(databus_out), 16'(e));
        check({tag, "_rxrd"}, 16'(rx_read), 16'(a == 2'b00));
        repeat (hold - 1) begin
            @(negedge clk);
            check({tag, "_hold"}, 16'(rx_read), 16'd0);
        end
        iocs = 1'b0;
        @(negedge clk);
        check({tag, "_keep"}, 16'(databus_out), 16'(e));
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d, input int hold);
        if (a == 2'b00) tx_q.push_back(d);
        iocs = 1'b1; iorw = 1'b0; ioaddr = a; databus_in = d;
        @(negedge clk);
        databus_in = ~d;
        repeat (hold - 1) @(negedge clk);
        iocs = 1'b0; iorw = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_tick(input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (baud_en !== 1'b1 && n < limit);
        if (baud_en !== 1'b1) n = -1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int c0;
        int t0;
        logic flag;
        logic [7:0] exp_hi;
        logic [7:0] exp_lo;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_databus_out", 16'(databus_out), 16'd0);
        check("rst_tx_data", 16'(tx_data), 16'd0);
        check("rst_rx_read", 16'(rx_read), 16'd0);
        check("rst_tx_write", 16'(tx_write), 16'd0);
        check("rst_baud_en", 16'(baud_en), 16'd0);
        rst = 1'b0;

        // Default divisor: first tick 163 cycles after release, then every 162
        wait_tick(400, n);
        check("first_tick", 16'(n), 16'd163);
        wait_tick(400, n);
        check("tick_period", 16'(n), 16'd162);

        // Divisor readback after reset
`ifdef SPART_DIVREAD_EN
        exp_hi = 8'h00; exp_lo = 8'hA2;
`else
        exp_hi = 8'h00; exp_lo = 8'h00;
`endif
        bus_read(2'b11, exp_hi, 1, "rd_dbhi");
        bus_read(2'b10, exp_lo, 1, "rd_dblo");

        // Divisor 5: LOAD on the cycle after the write, tick 5 cycles later
        bus_write(2'b10, 8'h05, 1);
        bus_write(2'b11, 8'h00, 1);
        wait_tick(50, n);
        check("div5_first", 16'(n), 16'd5);
        wait_tick(50, n);
        check("div5_period", 16'(n), 16'd5);

        // High-byte write lands on the same edge as a tick
        bus_write(2'b10, 8'h03, 1);
        wait_tick(50, n);
        repeat (4) @(negedge clk);
        iocs = 1'b1; iorw = 1'b0; ioaddr = 2'b11; databus_in = 8'h00;
        @(negedge clk);
        check("tick_on_write", 16'(baud_en), 16'd1);
        iocs = 1'b0; iorw = 1'b1;
        wait_tick(50, n);
        check("div3_first", 16'(n), 16'd4);
        wait_tick(50, n);
        check("div3_period", 16'(n), 16'd3);

        // Divisor 0 halts the generator
        bus_write(2'b10, 8'h00, 1);
        bus_write(2'b11, 8'h00, 1);
        flag = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (baud_en !== 1'b0) flag = 1'b1;
        end
        check("halt_quiet", 16'(flag), 16'd0);

        // Divisor 1 ticks every cycle
        bus_write(2'b10, 8'h01, 1);
        bus_write(2'b11, 8'h00, 1);
        flag = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (baud_en !== 1'b1) flag = 1'b0;
        end
        check("div1_every", 16'(flag), 16'd1);

        // Data read held 4 cycles: one rx_read pulse
        rda = 1'b1; rx_data = 8'hA5;
        c0 = rx_cnt;
        bus_read(2'b00, 8'hA5, 4, "rd_data");
        check("rx_pulses", 16'(rx_cnt - c0), 16'd1);

        // Data write with tbr low: still exactly one tx_write
        tbr = 1'b0;
        t0 = tx_cnt;
        bus_write(2'b00, 8'h3C, 3);
        check("tx_pulses", 16'(tx_cnt - t0), 16'd1);
        check("tx_data_hold", 16'(tx_data), 16'h003C);

        // Status reads, no side effects
        tbr = 1'b1; rda = 1'b0;
        c0 = rx_cnt;
        bus_read(2'b01, 8'h02, 2, "rd_status");
        tbr = 1'b0; rda = 1'b1;
        bus_read(2'b01, 8'h01, 1, "rd_status2");
        check("status_noside", 16'(rx_cnt - c0), 16'd0);

        // Write to status is ignored
        t0 = tx_cnt;
        bus_write(2'b01, 8'hFF, 1);
        check("wr_status_dout", 16'(databus_out), 16'h0001);
        check("wr_status_tx", 16'(tx_cnt - t0), 16'd0);

        // Reset during a held read
        rx_data = 8'h5A;
        iocs = 1'b1; iorw = 1'b1; ioaddr = 2'b00;
        @(negedge clk);
        check("pre_rst_rxrd", 16'(rx_read), 16'd1);
        check("pre_rst_dout", 16'(databus_out), 16'h005A);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_async_rxrd", 16'(rx_read), 16'd0);
        check("rst_async_dout", 16'(databus_out), 16'd0);
        @(negedge clk);
        rst = 1'b0;
        c0 = rx_cnt;
        repeat (5) @(negedge clk);
        #1;
        check("held_after_rst", 16'(rx_cnt - c0), 16'd0);
        iocs = 1'b0;
        @(negedge clk);
        bus_read(2'b00, 8'h5A, 1, "rd_after_rst");
        check("retoggle_pulse", 16'(rx_cnt - c0), 16'd1);

        check("tx_queue_empty", 16'(tx_q.size()), 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
